// File: rtl/clint_bus_arbiter_if.sv
// Bus bundle between the two CLINT requesters (core LSU = m0, debug host = m1),
// the arbiter and the CLINT register port.
// The "slave" modport is the arbiter's view: it accepts requests from the masters
// and drives the CLINT side. The "master" modport is the environment's view:
// the requesters plus the CLINT read-data source.
interface clint_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64,
    parameter int WLEN_W = 2
);
    // master 0: core load/store unit
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_wen;
    logic [XLEN-1:0]   m0_wdata;
    logic [WLEN_W-1:0] m0_wlen;
    logic              m0_lock;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [XLEN-1:0]   m0_rdata;

    // master 1: debug/test host
    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_wen;
    logic [XLEN-1:0]   m1_wdata;
    logic [WLEN_W-1:0] m1_wlen;
    logic              m1_lock;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [XLEN-1:0]   m1_rdata;

    // CLINT register port
    logic [ADDR_W-1:0] s_addr;
    logic              s_wen;
    logic [XLEN-1:0]   s_wdata;
    logic [WLEN_W-1:0] s_wlen;
    logic [XLEN-1:0]   s_rdata;

    // status
    logic [1:0]        owner;
    logic              lock_err;

    modport slave (
        input  m0_req, m0_addr, m0_wen, m0_wdata, m0_wlen, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_wen, m1_wdata, m1_wlen, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_addr, s_wen, s_wdata, s_wlen,
        input  s_rdata,
        output owner, lock_err
    );

    modport master (
        output m0_req, m0_addr, m0_wen, m0_wdata, m0_wlen, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_wen, m1_wdata, m1_wlen, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_addr, s_wen, s_wdata, s_wlen,
        output s_rdata,
        input  owner, lock_err
    );
endinterface

// File: rtl/clint_bus_arbiter.sv
// Two-master round-robin arbiter in front of the CLINT register port.
// Grants are single-cycle and combinational; a master may lock the port across
// several accesses (e.g. RV32 lo/hi mtimecmp write). A lock owner that stays idle
// for LOCK_TIMEOUT cycles is forcibly released and lock_err pulses in the cycle
// the release is decided. Read data is registered and returned one cycle after
// the granted read.
module clint_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int XLEN         = 64,
    parameter int WLEN_W       = 2,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rstn,
    clint_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    // Counter only needs to reach LOCK_TIMEOUT-1; keep at least one bit.
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              last_gnt_r;   // 0: m0 got the last grant, 1: m1
    logic              gnt0_s;
    logic              gnt1_s;
    logic              timeout_s;
    logic              rd_gnt_s;
    logic [1:0]        owner_r;
    logic              rvalid0_r;
    logic              rvalid1_r;
    logic [XLEN-1:0]   rdata_r;

    // Grant decision: round-robin when idle, owner-only while locked; nothing in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rstn) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.m0_req && bus.m1_req) begin
                        gnt0_s = last_gnt_r;
                        gnt1_s = ~last_gnt_r;
                    end else begin
                        gnt0_s = bus.m0_req;
                        gnt1_s = bus.m1_req;
                    end
                end
                ST_OWN0: gnt0_s = bus.m0_req;
                ST_OWN1: gnt1_s = bus.m1_req;
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Next-state, lock counter and timeout detection.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        timeout_s = 1'b0;
        if (gnt0_s) begin
            state_s = bus.m0_lock ? ST_OWN0 : ST_IDLE;
            cnt_s   = '0;
        end else if (gnt1_s) begin
            state_s = bus.m1_lock ? ST_OWN1 : ST_IDLE;
            cnt_s   = '0;
        end else if (rstn && (state_r != ST_IDLE)) begin
            if (cnt_r == CNT_LAST) begin
                state_s   = ST_IDLE;
                cnt_s     = '0;
                timeout_s = 1'b1;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = '0;
        end
    end

    assign rd_gnt_s = (gnt0_s & ~bus.m0_wen) | (gnt1_s & ~bus.m1_wen);

    // State, round-robin pointer, owner reflection and read-return registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            last_gnt_r <= 1'b1;
            owner_r    <= 2'b00;
            rvalid0_r  <= 1'b0;
            rvalid1_r  <= 1'b0;
            rdata_r    <= '0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            owner_r   <= state_s;
            rvalid0_r <= gnt0_s & ~bus.m0_wen;
            rvalid1_r <= gnt1_s & ~bus.m1_wen;
            if (gnt0_s) begin
                last_gnt_r <= 1'b0;
            end else if (gnt1_s) begin
                last_gnt_r <= 1'b1;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
            if (rd_gnt_s) begin
                rdata_r <= bus.s_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // CLINT side follows the granted master, defaulting to m0 when nobody is granted.
    assign bus.s_addr  = gnt1_s ? bus.m1_addr  : bus.m0_addr;
    assign bus.s_wdata = gnt1_s ? bus.m1_wdata : bus.m0_wdata;
    assign bus.s_wlen  = gnt1_s ? bus.m1_wlen  : bus.m0_wlen;
    assign bus.s_wen   = (gnt0_s & bus.m0_wen) | (gnt1_s & bus.m1_wen);

    assign bus.m0_gnt    = gnt0_s;
    assign bus.m1_gnt    = gnt1_s;
    assign bus.m0_rvalid = rvalid0_r;
    assign bus.m1_rvalid = rvalid1_r;
    assign bus.m0_rdata  = rdata_r;
    assign bus.m1_rdata  = rdata_r;
    assign bus.owner     = owner_r;
    assign bus.lock_err  = timeout_s;

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Directed, table-driven bench for clint_bus_arbiter, plus hand-written
// sequences for lock timeout and reset in the middle of a lock.
module tb_clint_bus_arbiter;

    localparam int ADDR_W = 64;
    localparam int XLEN   = 64;
    localparam int WLEN_W = 2;
    localparam int LOCK_TIMEOUT = 16;

    localparam logic [63:0] A0 = 64'h0000_0000_0200_4000;
    localparam logic [63:0] A1 = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] D0 = 64'h0000_0000_0000_0055;
    localparam logic [63:0] D1 = 64'h0000_0000_0000_00AA;
    localparam logic [1:0]  L0 = 2'b11;
    localparam logic [1:0]  L1 = 2'b10;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    clint_bus_arbiter_if #(.ADDR_W(ADDR_W), .XLEN(XLEN), .WLEN_W(WLEN_W)) bus();

    clint_bus_arbiter #(
        .ADDR_W(ADDR_W), .XLEN(XLEN), .WLEN_W(WLEN_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, w0, w1, l0, l1;
        logic [63:0] srd;
        logic        eg0, eg1, eswen;
        logic [1:0]  eown;
        logic        erv0, erv1;
        logic [63:0] erd;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r0, input logic r1, input logic w0, input logic w1,
                          input logic l0, input logic l1, input logic [63:0] srd);
        bus.m0_req = r0; bus.m0_wen = w0; bus.m0_lock = l0;
        bus.m1_req = r1; bus.m1_wen = w1; bus.m1_lock = l1;
        bus.s_rdata = srd;
    endtask

    task automatic apply(input vec_t v, input int idx);
        set_in(v.r0, v.r1, v.w0, v.w1, v.l0, v.l1, v.srd);
        #3;
        chk($sformatf("v%0d_gnt0", idx), 64'(bus.m0_gnt), 64'(v.eg0));
        chk($sformatf("v%0d_gnt1", idx), 64'(bus.m1_gnt), 64'(v.eg1));
        chk($sformatf("v%0d_swen", idx), 64'(bus.s_wen), 64'(v.eswen));
        chk($sformatf("v%0d_saddr", idx), bus.s_addr, v.eg1 ? A1 : A0);
        chk($sformatf("v%0d_swdata", idx), bus.s_wdata, v.eg1 ? D1 : D0);
        chk($sformatf("v%0d_swlen", idx), 64'(bus.s_wlen), 64'(v.eg1 ? L1 : L0));
        chk($sformatf("v%0d_lockerr", idx), 64'(bus.lock_err), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_rvalid0", idx), 64'(bus.m0_rvalid), 64'(v.erv0));
        chk($sformatf("v%0d_rvalid1", idx), 64'(bus.m1_rvalid), 64'(v.erv1));
        chk($sformatf("v%0d_owner", idx), 64'(bus.owner), 64'(v.eown));
        chk($sformatf("v%0d_rdata0", idx), bus.m0_rdata, v.erd);
        chk($sformatf("v%0d_rdata1", idx), bus.m1_rdata, v.erd);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus.m0_addr = A0; bus.m0_wdata = D0; bus.m0_wlen = L0;
        bus.m1_addr = A1; bus.m1_wdata = D1; bus.m1_wlen = L1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

        //          r0   r1   w0   w1   l0   l1   s_rdata        g0   g1   swen own   rv0  rv1  rdata
        vt[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,64'h0000_DEAD,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,64'h0};
        vt[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,64'h0000_1234,1'b0,1'b1,1'b0,2'b00,1'b0,1'b1,64'h1234};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,64'h0000_BEEF,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,64'h1234};
        vt[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,64'h0000_0011,1'b1,1'b0,1'b0,2'b00,1'b1,1'b0,64'h11};
        vt[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,64'h0000_0022,1'b0,1'b1,1'b0,2'b00,1'b0,1'b1,64'h22};
        vt[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,64'h0000_0033,1'b1,1'b0,1'b0,2'b00,1'b1,1'b0,64'h33};
        vt[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,64'h0000_0044,1'b0,1'b1,1'b0,2'b00,1'b0,1'b1,64'h44};
        vt[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,64'h0000_DEAD,1'b1,1'b0,1'b1,2'b01,1'b0,1'b0,64'h44};
        vt[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,64'h0000_DEAD,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,64'h44};
        vt[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,64'h0000_DEAD,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,64'h44};
        vt[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,64'h0000_DEAD,1'b0,1'b1,1'b1,2'b00,1'b0,1'b0,64'h44};

        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        #3;
        chk("rst_gnt0", 64'(bus.m0_gnt), 64'd0);
        chk("rst_gnt1", 64'(bus.m1_gnt), 64'd0);
        chk("rst_owner", 64'(bus.owner), 64'd0);
        chk("rst_rvalid0", 64'(bus.m0_rvalid), 64'd0);
        chk("rst_rvalid1", 64'(bus.m1_rvalid), 64'd0);
        chk("rst_lockerr", 64'(bus.lock_err), 64'd0);
        chk("rst_rdata", bus.m0_rdata, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            apply(vt[i], i);
        end

        // Lock timeout: m0 locked write alone, then m0 goes quiet while m1 waits.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0);
        #3;
        chk("to_grant_m0", 64'(bus.m0_gnt), 64'd1);
        @(posedge clk); #1;
        chk("to_owner_locked", 64'(bus.owner), 64'd1);
        for (int k = 1; k <= LOCK_TIMEOUT; k++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h77);
            #3;
            chk($sformatf("to_c%0d_gnt1", k), 64'(bus.m1_gnt), 64'd0);
            chk($sformatf("to_c%0d_lockerr", k), 64'(bus.lock_err), (k == LOCK_TIMEOUT) ? 64'd1 : 64'd0);
            chk($sformatf("to_c%0d_owner", k), 64'(bus.owner), 64'd1);
            @(posedge clk); #1;
        end
        // m1 granted right after the forced release, taking the lock with a read.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h77);
        #3;
        chk("to_after_gnt1", 64'(bus.m1_gnt), 64'd1);
        chk("to_after_lockerr", 64'(bus.lock_err), 64'd0);
        chk("to_after_owner", 64'(bus.owner), 64'd0);
        @(posedge clk); #1;
        chk("lk1_owner", 64'(bus.owner), 64'd2);
        chk("lk1_rvalid1", 64'(bus.m1_rvalid), 64'd1);
        chk("lk1_rvalid0", 64'(bus.m0_rvalid), 64'd0);
        chk("lk1_rdata", bus.m1_rdata, 64'h77);

        // Reset while m1 owns the lock and keeps requesting.
        rstn = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h99);
        #3;
        chk("rl_gnt1_in_reset", 64'(bus.m1_gnt), 64'd0);
        chk("rl_swen_in_reset", 64'(bus.s_wen), 64'd0);
        @(posedge clk); #1;
        chk("rl_owner", 64'(bus.owner), 64'd0);
        chk("rl_rvalid0", 64'(bus.m0_rvalid), 64'd0);
        chk("rl_rvalid1", 64'(bus.m1_rvalid), 64'd0);
        chk("rl_lockerr", 64'(bus.lock_err), 64'd0);
        rstn = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h5A5A);
        #3;
        chk("rl_m0_gnt", 64'(bus.m0_gnt), 64'd1);
        chk("rl_m1_gnt", 64'(bus.m1_gnt), 64'd0);
        @(posedge clk); #1;
        chk("rl_m0_rvalid", 64'(bus.m0_rvalid), 64'd1);
        chk("rl_m0_rdata", bus.m0_rdata, 64'h5A5A);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clint_bus_arbiter.md
Name: clint_bus_arbiter

Overview:
Two-master arbiter in front of the CLINT register port (mtime/mtimecmp). Master 0 is the core load/store unit; master 1 is the debug/test host port. Round-robin single-cycle grants. A lock mechanism lets one master keep ownership across several accesses, e.g. an RV32 lo/hi split write of mtimecmp, so the other master cannot interleave. Read data returns one cycle after the grant.

Parameters:
ADDR_W, 64, address width of master and slave ports
XLEN, 64, data width (32 for RV32 builds)
WLEN_W, 2, access-length code width; the code is passed through unchanged
LOCK_TIMEOUT, 16, idle cycles of a lock owner before forced release (must be >= 1)

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
m0_req  in  1  master 0 access request (level, held until granted)
m0_addr  in  ADDR_W  master 0 byte address
m0_wen  in  1  master 0 write enable (0 = read)
m0_wdata  in  XLEN  master 0 write data
m0_wlen  in  WLEN_W  master 0 access length
m0_lock  in  1  keep ownership after this access
m0_gnt  out  1  access accepted this cycle
m0_rvalid  out  1  read data valid (one cycle after a granted read)
m0_rdata  out  XLEN  read data
m1_req, m1_addr, m1_wen, m1_wdata, m1_wlen, m1_lock, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for master 1
s_addr  out  ADDR_W  to CLINT data_addr
s_wen  out  1  to CLINT wen; high only on a granted write
s_wdata  out  XLEN  to CLINT wdata
s_wlen  out  WLEN_W  to CLINT wlen
s_rdata  in  XLEN  CLINT combinational read data for s_addr
owner  out  2  current lock owner: 00 none, 01 m0, 10 m1
lock_err  out  1  one-cycle pulse on lock timeout release

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Reset: IDLE, last_gnt=1 (m0 wins the first tie), timeout counter 0, all outputs 0.
- Grant is combinational from the state, the req inputs and last_gnt.
  - IDLE: only one req high → grant it. Both high → grant the master that is not last_gnt.
  - OWNx: only mx may be granted. The other master's gnt is 0 even if it is requesting.
- At most one gnt is high per cycle.
- The s_* address, wdata and wlen mux follow the granted master; with no grant they follow m0. s_wen = granted & wen.
- A granted write is committed by the CLINT in the same cycle, so write latency is 0.
- A granted read latches s_rdata into an rdata register. The rvalid of the granted master is high in the next cycle only.
- rdata holds its value until the next granted read; rvalid of the other master stays 0.
- last_gnt updates to the granted master on every grant.
- Transitions:
  - Granted mx with mx_lock=1: go to OWNx, clear the counter.
  - Granted mx with mx_lock=0: go to IDLE (this includes OWNx → IDLE, which releases the lock).
  - In OWNx with no grant this cycle: counter++. When the counter reaches LOCK_TIMEOUT-1 and still no grant, go to IDLE and pulse lock_err for 1 cycle.
  - A grant in OWNx clears the counter.
- In OWNx, a request from the owner is granted in the same cycle regardless of the other master's request.
- A lock request on a read is honoured the same way as on a write.
- owner is a registered reflection of the state.
- Reset mid-lock (rstn=0): next edge returns to IDLE, pending rvalid is dropped, lock_err=0.
- No back-to-back restriction: a master can be granted every cycle.

Test Plan:
- Single write: m0_req=1, wen=1, addr=0x0200_4000, wdata=0x55, wlen=DWORD → m0_gnt=1 and s_wen=1 in the same cycle; s_wdata=0x55; owner=00.
- Read: m1 read of 0x0200_BFF8 with s_rdata=0x1234 → m1_gnt=1 at cycle t; m1_rvalid=1 and m1_rdata=0x1234 at t+1 only; m0_rvalid=0.
- Round-robin: both masters request continuously with lock=0 for 4 cycles after reset → grants go m0, m1, m0, m1.
- RV32 split write under contention: m0 writes lo word with lock=1, m1 requests from that point on, then m0 writes hi word with lock=0 two cycles later → m1_gnt=0 until m0's hi write; owner=01 in between; m1 is granted the cycle after the release.
- Timeout: m0 locked write, then m0_req=0 with LOCK_TIMEOUT=16 → lock_err pulses exactly 16 cycles after the grant; owner=00; waiting m1 is granted the following cycle.
- Reset mid-lock: rstn=0 for one edge while owner=10 → owner=00, all gnt/rvalid=0; the next m0 request is granted immediately.
